// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder that pushes one 4-bit nibble per clock
//   through a single carry-lookahead slice, LSB nibble first.
//   valid/ready handshakes on both the operand side and the result side.
//   Optional feature macro: NIBBLE_SERIAL_OVF_EN adds the signed-overflow
//   output ovf; with it undefined the port and its logic do not exist.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid && ready are both 1. A producer holding valid keeps its
// payload stable until that edge; ready may change freely and does not
// depend combinationally on valid. Here in_ready is decoded from state only,
// and out_valid is a register that stays high (with sum/c_out/ovf frozen)
// until out_ready is seen.

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    // WIDTH is expected to be a multiple of 4 and at least 4.
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice_res;
    logic             last_slice;

    assign in_ready   = (state == IDLE);
    assign last_slice = (idx == IDX_W'(NSLICE - 1));

    // Select the operand nibbles addressed by the current slice index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                a_nib = a_r[4*i +: 4];
                b_nib = b_r[4*i +: 4];
            end
        end
    end

    // The 4-bit slice: nibble sum in [3:0], carry-out in [4].
    always_comb begin
        slice_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    end

    // Control FSM plus operand capture and nibble-by-nibble result writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= c;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= slice_res[4];
                    // Only the addressed nibble changes; the rest keep old data.
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum[4*i +: 4] <= slice_res[3:0];
                        end
                    end
                    if (last_slice) begin
                        c_out     <= slice_res[4];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef NIBBLE_SERIAL_OVF_EN
    // Signed overflow: carry into the MSB xor carry out of the MSB, taken
    // from the top slice. The carry into bit 3 is recovered from the sum bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == RUN && last_slice) begin
            ovf <= slice_res[4] ^ (slice_res[3] ^ a_nib[3] ^ b_nib[3]);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Randomized and directed bench for nibble_serial_adder (WIDTH=16).
//   Expected results come from plain integer arithmetic on the operands.
//   Build with NIBBLE_SERIAL_OVF_EN defined to also check ovf.

module tb_nibble_serial_adder;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic             ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard entries: {ovf, c_out, sum}.
    logic [WIDTH+1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef NIBBLE_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic mc);
        logic [WIDTH:0] full;
        logic           sovf;
        full = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
        sovf = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        return {sovf, full};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_result(input logic [WIDTH+1:0] e);
        check("out_valid", out_valid, 1);
        check("sum", sum, e[WIDTH-1:0]);
        check("c_out", c_out, e[WIDTH]);
`ifdef NIBBLE_SERIAL_OVF_EN
        check("ovf", ovf, e[WIDTH+1]);
`endif
        check("done_in_ready", in_ready, 0);
    endtask

    // ---------------- driver ----------------
    // One full add: handshake in, latency check, hold for 'hold' extra
    // cycles with out_ready low, then consume. With noise set, in_valid and
    // the operand bus toggle while the block is busy and must be ignored.
    task automatic do_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input int hold, input bit noise);
        int waitc;
        int lat;
        logic [WIDTH+1:0] e;
        @(negedge clk);
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("accept_ready", in_ready, 1);
        a        = ta;
        b        = tb_;
        c        = tc;
        in_valid = 1'b1;
        exp_q.push_back(model(ta, tb_, tc));
        @(negedge clk);
        check("busy_in_ready", in_ready, 0);
        in_valid = noise;
        lat = 0;
        while (!out_valid && lat < 4 * NSLICE + 4) begin
            if (noise) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                c = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NSLICE);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int h = 0; h <= hold; h++) begin
            check_result(e);
            if (h < hold) @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c         = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
`ifdef NIBBLE_SERIAL_OVF_EN
        check("rst_ovf", ovf, 0);
`endif

        // out_ready with nothing pending does nothing.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_ready_valid", out_valid, 0);
        check("idle_ready_in_ready", in_ready, 1);

        // Directed cases.
        do_add(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        do_add(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        do_add(16'h8000, 16'h8000, 1'b0, 5, 1'b0);

        // Abort in the middle of RUN.
        @(negedge clk);
        a        = 16'hABCD;
        b        = 16'h1111;
        c        = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_sum", sum, 0);
        check("abort_c_out", c_out, 0);
        for (int i = 0; i < NSLICE + 2; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
        do_add(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);

`ifdef NIBBLE_SERIAL_OVF_EN
        do_add(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        do_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        do_add(16'h8000, 16'hFFFF, 1'b0, 1, 1'b0);
`endif

        // Randomized adds with random result back-pressure and bus noise.
        for (int n = 0; n < 60; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if (n % 10 == 3) rb = ~ra;
            do_add(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
